// File: rtl/comparador_pkg.sv
// Shared definitions for the serial equality comparator.
//   state_t : FSM encoding used by comparador_serial (IDLE, COMPARE, DONE)
//   SLICE_W : number of operand bits examined per clock
package comparador_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int SLICE_W = 2;

endpackage : comparador_pkg

// File: rtl/comparador_2bits.sv
// 2-bit equality comparator (combinational).
//   A, B : 2-bit slices to compare
//   X    : 1 when A == B
module comparador_2bits (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       X
);

  assign X = (A == B);

endmodule : comparador_2bits

// File: rtl/comparador_serial.sv
// Sequential WIDTH-bit equality comparator. Walks both operands MSB-first,
// one 2-bit slice per clock, through a single comparador_2bits instance,
// and reports whether the words are equal and which slice mismatched first.
//
// Optional build macro: COMPARADOR_SERIAL_EARLY_EXIT_EN
//   defined   : leave COMPARE on the first mismatching slice
//   undefined : always scan all N slices (fixed latency)
//
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   start    : request, only honoured in IDLE
//   a_in     : operand A, captured on the accepted start edge
//   b_in     : operand B, captured on the accepted start edge
//   busy     : high in COMPARE and DONE
//   done     : one-cycle pulse, eq/diff_idx valid
//   eq       : 1 = operands equal, held until the next result
//   diff_idx : first mismatching slice (0 = MSB slice), 0 when equal, held
//
// Handshake: start is a level sampled on each edge while IDLE; the edge that
// sees start=1 in IDLE captures the operands. There is no backpressure on the
// result: done is a single-cycle pulse and eq/diff_idx stay valid afterwards.
module comparador_serial
  import comparador_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int N     = WIDTH / 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IDX_W-1:0] diff_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             eq_acc_q, eq_acc_d;
  logic             seen_q, seen_d;
  logic [IDX_W-1:0] diff_acc_q, diff_acc_d;
  logic             eq_q, eq_d;
  logic [IDX_W-1:0] diff_idx_q, diff_idx_d;

  logic             slice_eq;
  logic             first_miss;
  logic             last_slice;
  logic             finish;

  comparador_2bits u_cmp (
    .A (a_sh_q[WIDTH-1 -: SLICE_W]),
    .B (b_sh_q[WIDTH-1 -: SLICE_W]),
    .X (slice_eq)
  );

  // First mismatch in this operation: only the earliest slice is recorded.
  assign first_miss = !slice_eq && !seen_q;
  assign last_slice = (cnt_q == LAST_IDX);

`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
  assign finish = last_slice || !slice_eq;
`else
  assign finish = last_slice;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      cnt_q      <= '0;
      eq_acc_q   <= 1'b0;
      seen_q     <= 1'b0;
      diff_acc_q <= '0;
      eq_q       <= 1'b0;
      diff_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      cnt_q      <= cnt_d;
      eq_acc_q   <= eq_acc_d;
      seen_q     <= seen_d;
      diff_acc_q <= diff_acc_d;
      eq_q       <= eq_d;
      diff_idx_q <= diff_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    cnt_d      = cnt_q;
    eq_acc_d   = eq_acc_q;
    seen_d     = seen_q;
    diff_acc_d = diff_acc_q;
    eq_d       = eq_q;
    diff_idx_d = diff_idx_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d     = a_in;
          b_sh_d     = b_in;
          cnt_d      = '0;
          eq_acc_d   = 1'b1;
          seen_d     = 1'b0;
          diff_acc_d = '0;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        eq_acc_d = eq_acc_q & slice_eq;
        if (first_miss) begin
          diff_acc_d = cnt_q;
          seen_d     = 1'b1;
        end
        a_sh_d = a_sh_q << SLICE_W;
        b_sh_d = b_sh_q << SLICE_W;
        cnt_d  = cnt_q + IDX_W'(1);
        if (finish) begin
          // Published results include the slice being compared on this edge.
          eq_d       = eq_acc_q & slice_eq;
          diff_idx_d = first_miss ? cnt_q : diff_acc_q;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign eq       = eq_q;
  assign diff_idx = diff_idx_q;

endmodule : comparador_serial

// File: tb/tb_comparador_serial.sv
// Self-checking bench for comparador_serial (WIDTH=8). Expected results come
// from a slice-by-slice arithmetic model; a queue holds expected verdicts
// which are retired on every done pulse.
module tb_comparador_serial;

  localparam int WIDTH = 8;
  localparam int N     = WIDTH / 2;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             eq;
  logic [IDX_W-1:0] diff_idx;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int last_done_edge = 0;

  logic [IDX_W:0] exp_q[$];
  logic [IDX_W:0] exp_e;

  comparador_serial #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .eq       (eq),
    .diff_idx (diff_idx)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Slice i covers bits [WIDTH-1-2i -: 2]; extracted with plain arithmetic.
  function automatic int first_diff(input int a, input int b);
    for (int i = 0; i < N; i++) begin
      int sh = WIDTH - 2 * (i + 1);
      if (((a >> sh) % 4) != ((b >> sh) % 4)) return i;
    end
    return -1;
  endfunction

  function automatic int exp_latency(input int a, input int b);
    int k = first_diff(a, b);
`ifdef COMPARADOR_SERIAL_EARLY_EXIT_EN
    if (k >= 0) return k + 2;
`endif
    return N + 1;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && done) begin
      last_done_edge = edge_cnt;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("eq", eq, exp_e[IDX_W]);
        chk("diff_idx", diff_idx, exp_e[IDX_W-1:0]);
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge. hold keeps start high; intrude fires a second
  // request (11/22) while the first operation is busy.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input bit hold, input bit intrude);
    int guard = 0;
    int k, lat_e, t0, n, busy_cycles;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      chk("idle_timeout", 1, 0);
      return;
    end
    k     = first_diff(a, b);
    lat_e = exp_latency(a, b);
    exp_q.push_back({(k < 0), (k < 0) ? IDX_W'(0) : IDX_W'(k)});
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    t0    = edge_cnt;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_after_start", busy, 1);
    busy_cycles = busy ? 1 : 0;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (intrude && n == 3) begin
        a_in  = 8'h11;
        b_in  = 8'h22;
        start = 1'b1;
      end else if (intrude && n == 4) begin
        start = 1'b0;
      end
      if (busy) busy_cycles++;
    end
    if (!done) begin
      chk("done_timeout", 1, 0);
      return;
    end
    chk("latency", edge_cnt - t0, lat_e);
    chk("busy_cycles", busy_cycles, lat_e);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("busy_drop", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int prev;
    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_eq", eq, 0);
    chk("rst_diff_idx", diff_idx, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(8'hA5, 8'hA5, 1'b0, 1'b0);
    do_op(8'hA5, 8'hA4, 1'b0, 1'b0);
    do_op(8'h25, 8'hA5, 1'b0, 1'b0);
    do_op(8'h11, 8'h11, 1'b0, 1'b1);

    // Reset two edges into COMPARE; eq is 1 from the previous result.
    start = 1'b1;
    a_in  = 8'h3C;
    b_in  = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_eq", eq, 0);
    chk("midrst_diff_idx", diff_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("midrst_no_done_busy", busy, 0);
    do_op(8'h0F, 8'h0E, 1'b0, 1'b0);

    // Held start with alternating equal / last-slice-unequal pairs.
    for (int i = 0; i < 6; i++) begin
      logic [WIDTH-1:0] a;
      a = WIDTH'($urandom_range(0, 255));
      prev = last_done_edge;
      do_op(a, (i % 2 == 0) ? a : (a ^ 8'h01), 1'b1, 1'b0);
      if (i > 0) chk("held_period", last_done_edge - prev, N + 2);
    end
    start = 1'b0;
    @(negedge clk);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      logic [WIDTH-1:0] a, b;
      int mode;
      a    = WIDTH'($urandom_range(0, 255));
      mode = $urandom_range(0, 2);
      if (mode == 0)      b = a;
      else if (mode == 1) b = WIDTH'($urandom_range(0, 255));
      else                b = a ^ WIDTH'(32'd1 << (2 * $urandom_range(0, N - 1) + $urandom_range(0, 1)));
      do_op(a, b, 1'b0, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_comparador_serial

// File: doc/comparador_serial.md
Name: comparador_serial

Overview:
- Sequential multi-bit equality comparator that walks two WIDTH-bit operands MSB-first, one 2-bit slice per clock.
- Feeds each slice pair into a 2-bit equality comparator (comparador_2bits) and consumes its X output.
- Accumulates the per-slice results into a word-level verdict and reports the first mismatching slice.
- Sits directly upstream of, and drives, the existing 2-bit comparator; replaces a wide combinational compare where area matters more than latency.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- N (localparam), WIDTH/2, number of 2-bit slices.
- IDX_W (localparam), max(1, $clog2(N)), width of diff_idx.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A, captured on the accepted start edge.
- b_in  input  WIDTH  operand B, captured on the accepted start edge.
- busy  output  1  high in COMPARE and DONE.
- done  output  1  single-cycle pulse; results valid.
- eq  output  1  1 = operands equal; held until next accepted start.
- diff_idx  output  IDX_W  index of first mismatching slice (0 = MSB slice); 0 when eq=1; held.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, eq=0, diff_idx=0, shift registers=0, slice counter=0, mismatch-seen flag=0.
- IDLE:
  - When start=1 at a rising edge: load a_in/b_in into shift registers, counter=0, eq accumulator=1, mismatch-seen=0, go to COMPARE.
  - Otherwise stay in IDLE.
- COMPARE, each edge:
  - Drive the top 2 bits of each shift register into comparador_2bits.
  - eq_acc <= eq_acc & X.
  - If X=0 and mismatch-seen=0: diff_idx <= counter and mismatch-seen <= 1.
  - Shift both registers left by 2; counter++.
  - After the slice with counter=N-1 is compared, go to DONE.
- DONE (one cycle): done=1, eq=eq_acc, busy=1; next edge go to IDLE.
- Latency: done is high in the cycle after the (N+1)th rising edge following the accepted start edge. For WIDTH=8, done appears 5 edges after start.
- Throughput: one operation per N+2 edges. With start held high, a new operation is accepted on the first edge spent in IDLE.
- start asserted while busy=1 is ignored; operands are not recaptured.
- eq and diff_idx change only on the DONE transition; they are stable between operations.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous). The operation is discarded with no done pulse.
- WIDTH=2 (N=1): COMPARE lasts one edge; diff_idx is 1 bit and always 0.

Optional Feature:
- Macro: COMPARADOR_SERIAL_EARLY_EXIT_EN
- Defined:
  - On the first slice with X=0, transition from COMPARE directly to DONE on that same edge.
  - With the first mismatch at slice k, done appears k+2 edges after start.
  - Equal operands still take N+1 edges.
- Undefined: always scan all N slices; latency is fixed at N+1 edges regardless of data.
- eq and diff_idx values are identical in both builds.

Decomposition:
- Shared package comparador_pkg:
  - state typedef enum logic [1:0] {IDLE, COMPARE, DONE}.
  - localparam SLICE_W = 2.
- One sub-module: comparador_2bits (existing), instantiated once for the per-slice compare.
- Counter, shift registers and FSM live in comparador_serial.

Test Plan:
- WIDTH=8, a_in=8'hA5, b_in=8'hA5, start pulse -> done pulse 5 edges later, eq=1, diff_idx=0, busy high for 5 cycles.
- a_in=8'hA5, b_in=8'hA4 -> eq=0, diff_idx=3, done 5 edges after start in both builds.
- a_in=8'h25, b_in=8'hA5 -> eq=0, diff_idx=0; done 5 edges after start without the macro, 2 edges with COMPARADOR_SERIAL_EARLY_EXIT_EN.
- Start with 8'h11/8'h11, then pulse start with 8'h11/8'h22 while busy -> second request ignored; result eq=1, and busy drops in the cycle after done.
- Assert reset for 1 cycle 2 edges into COMPARE -> busy=0, done=0, eq=0 immediately, no done pulse. A following start with 8'h0F/8'h0E completes with eq=0, diff_idx=3.
- Hold start=1 continuously with alternating equal/unequal operands -> done pulses every 6 edges, results match each captured pair.
